// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network readout blocks.
//   - default sizing for the output layer and spike counters
//   - scan FSM state encoding
//   - saturating increment used by the per-neuron counters
package snn_pkg;

   localparam int N_OUTPUT_DEF = 3;
   localparam int COUNT_W_DEF  = 8;
   localparam int WINDOW_DEF   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2
   } scan_state_t;

   // Adds one when inc is set, but never goes past max_val.
   function automatic int unsigned sat_inc(input int unsigned value,
                                           input logic        inc,
                                           input int unsigned max_val);
      if (inc && (value < max_val))
         return value + 1;
      return value;
   endfunction

endpackage

// File: rtl/spike_counter_bank.sv
// Per-neuron saturating spike counters over fixed windows of enabled cycles.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            counting enable; low clears counters and window index
//   spikes_in     one bit per neuron, 1 = spiked this cycle
//   win_counts    counter values including this cycle's spikes (flat,
//                 neuron i at [i*COUNT_W +: COUNT_W])
//   win_end       high on the last enabled cycle of a window
//
// win_counts already includes the current cycle's spikes so the snapshot
// taken on the window-end edge sees all WINDOW cycles.
module spike_counter_bank
   import snn_pkg::*;
#(
   parameter int N_OUTPUT = N_OUTPUT_DEF,
   parameter int WINDOW   = WINDOW_DEF,
   parameter int COUNT_W  = COUNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [N_OUTPUT-1:0]         spikes_in,
   output logic [N_OUTPUT*COUNT_W-1:0] win_counts,
   output logic                        win_end
);

   localparam int          WIN_W   = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam int unsigned CNT_MAX = (32'd1 << COUNT_W) - 32'd1;

   logic [COUNT_W-1:0] cnt_q [N_OUTPUT];
   logic [WIN_W-1:0]   idx_q;

   assign win_end = en && (idx_q == WIN_W'(WINDOW - 1));

   always_comb begin
      win_counts = '0;
      for (int i = 0; i < N_OUTPUT; i++)
         win_counts[i*COUNT_W +: COUNT_W] =
            COUNT_W'(sat_inc(32'(cnt_q[i]), spikes_in[i], CNT_MAX));
   end

   // Abort (en low) and window end both restart counting from zero; the
   // window-end case differs only in that the top level grabs win_counts.
   always_ff @(posedge clk) begin
      if (rst || !en || win_end) begin
         for (int i = 0; i < N_OUTPUT; i++)
            cnt_q[i] <= '0;
         idx_q <= '0;
      end else begin
         for (int i = 0; i < N_OUTPUT; i++)
            cnt_q[i] <= win_counts[i*COUNT_W +: COUNT_W];
         idx_q <= idx_q + WIN_W'(1);
      end
   end

endmodule

// File: rtl/spike_count_decoder.sv
// Readout stage for the spiking network: counts output spikes per neuron
// over WINDOW enabled cycles, snapshots the counts at each window end,
// scans them for the maximum and offers the decision on a valid/ready port.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   en              counting enable; low aborts the current window
//   spikes_in       per-neuron spike vector
//   result_valid    result available, held until accepted
//   result_ready    consumer accept
//   result_counts   snapshot counts, neuron i at [i*COUNT_W +: COUNT_W]
//   result_winner   index of the highest count (lowest index on ties)
//   result_max      count of the winner
//   result_none     all snapshot counts were zero
//   overrun         sticky: a completed window was dropped
//   clear_overrun   clears overrun (a same-cycle drop wins)
//
// state | meaning
// IDLE  | waiting for a window end to load the snapshot
// SCAN  | comparing one snapshot entry per cycle, index 0 .. N_OUTPUT-1
// HOLD  | result_valid high, waiting for result_ready
module spike_count_decoder
   import snn_pkg::*;
#(
   parameter int N_OUTPUT = N_OUTPUT_DEF,
   parameter int WINDOW   = WINDOW_DEF,
   parameter int COUNT_W  = COUNT_W_DEF,
   parameter int IDX_W    = $clog2(N_OUTPUT)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [N_OUTPUT-1:0]         spikes_in,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic [N_OUTPUT*COUNT_W-1:0] result_counts,
   output logic [IDX_W-1:0]            result_winner,
   output logic [COUNT_W-1:0]          result_max,
   output logic                        result_none,
   output logic                        overrun,
   input  logic                        clear_overrun
);

   logic [N_OUTPUT*COUNT_W-1:0] win_counts;
   logic                        win_end;

   spike_counter_bank #(
      .N_OUTPUT (N_OUTPUT),
      .WINDOW   (WINDOW),
      .COUNT_W  (COUNT_W)
   ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .spikes_in  (spikes_in),
      .win_counts (win_counts),
      .win_end    (win_end)
   );

   scan_state_t                 state_q, state_d;
   logic [N_OUTPUT*COUNT_W-1:0] snap_q;
   logic [IDX_W-1:0]            scan_idx_q;
   logic [IDX_W-1:0]            best_idx_q;
   logic [COUNT_W-1:0]          best_max_q;
   logic                        none_q;
   logic                        overrun_q;

   logic               accept;
   logic               snap_load;
   logic               drop;
   logic               scan_last;
   logic [COUNT_W-1:0] cur_count;
   logic               take;

   assign accept    = (state_q == ST_HOLD) && result_ready;
   // The snapshot may only change while nobody is looking at it: in IDLE,
   // or on the very edge the held result is being accepted.
   assign snap_load = win_end && ((state_q == ST_IDLE) || accept);
   assign drop      = win_end && !snap_load;
   assign scan_last = (scan_idx_q == IDX_W'(N_OUTPUT - 1));
   assign cur_count = snap_q[32'(scan_idx_q)*COUNT_W +: COUNT_W];
   // Strict compare keeps the earlier index on ties.
   assign take      = (cur_count > best_max_q);

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (snap_load)
               state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (scan_last)
               state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (accept)
               state_d = snap_load ? ST_SCAN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q     <= '0;
         scan_idx_q <= '0;
         best_idx_q <= '0;
         best_max_q <= '0;
         none_q     <= 1'b0;
      end else if (snap_load) begin
         snap_q     <= win_counts;
         scan_idx_q <= '0;
         best_idx_q <= '0;
         best_max_q <= '0;
         none_q     <= 1'b0;
      end else if (state_q == ST_SCAN) begin
         if (take) begin
            best_idx_q <= scan_idx_q;
            best_max_q <= cur_count;
         end
         if (scan_last)
            // take implies a nonzero count, so the final max is zero only
            // if nothing was taken and the running max is still zero.
            none_q <= !take && (best_max_q == '0);
         else
            scan_idx_q <= scan_idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         overrun_q <= 1'b0;
      else if (drop)
         overrun_q <= 1'b1;
      else if (clear_overrun)
         overrun_q <= 1'b0;
   end

   assign result_valid  = (state_q == ST_HOLD);
   assign result_counts = snap_q;
   assign result_winner = best_idx_q;
   assign result_max    = best_max_q;
   assign result_none   = none_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_spike_count_decoder.sv
module tb_spike_count_decoder;

   logic        clk;
   logic        rst;
   logic        en;
   logic [2:0]  spikes_in;
   logic        result_ready;
   logic        clear_overrun;

   logic        result_valid;
   logic [23:0] result_counts;
   logic [1:0]  result_winner;
   logic [7:0]  result_max;
   logic        result_none;
   logic        overrun;

   logic        sat_valid;
   logic [8:0]  sat_counts;
   logic [1:0]  sat_winner;
   logic [2:0]  sat_max;
   logic        sat_none;
   logic        sat_overrun;

   int n_total = 0;
   int n_bad   = 0;

   spike_count_decoder #(.N_OUTPUT(3), .WINDOW(16), .COUNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .spikes_in     (spikes_in),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .result_counts (result_counts),
      .result_winner (result_winner),
      .result_max    (result_max),
      .result_none   (result_none),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   // Narrow-counter instance sharing all inputs, used for saturation.
   spike_count_decoder #(.N_OUTPUT(3), .WINDOW(16), .COUNT_W(3)) dut_sat (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .spikes_in     (spikes_in),
      .result_valid  (sat_valid),
      .result_ready  (result_ready),
      .result_counts (sat_counts),
      .result_winner (sat_winner),
      .result_max    (sat_max),
      .result_none   (sat_none),
      .overrun       (sat_overrun),
      .clear_overrun (clear_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 ns later.
   task automatic cyc(input logic e, input logic [2:0] s);
      en        = e;
      spikes_in = s;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_result(input string tag, input logic [23:0] counts,
                             input logic [1:0] winner, input logic [7:0] max,
                             input logic none);
      chk({tag, "_valid"},  32'(result_valid),  32'd1);
      chk({tag, "_counts"}, 32'(result_counts), 32'(counts));
      chk({tag, "_winner"}, 32'(result_winner), 32'(winner));
      chk({tag, "_max"},    32'(result_max),    32'(max));
      chk({tag, "_none"},   32'(result_none),   32'(none));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; spikes_in = '0; result_ready = 1'b1; clear_overrun = 1'b0;
      cyc(0, 3'b000);
      cyc(0, 3'b000);
      chk("rst_valid",   32'(result_valid),  32'd0);
      chk("rst_counts",  32'(result_counts), 32'd0);
      chk("rst_winner",  32'(result_winner), 32'd0);
      chk("rst_max",     32'(result_max),    32'd0);
      chk("rst_overrun", 32'(overrun),       32'd0);
      rst = 1'b0;

      // Basic window: n0 every 2nd cycle (8), n2 every 4th (4), n1 none.
      for (int c = 0; c < 16; c++)
         cyc(1, {(c % 4) == 0, 1'b0, (c % 2) == 0});
      chk("basic_e0_valid", 32'(result_valid), 32'd0);
      cyc(0, 3'b000);
      chk("basic_e1_valid", 32'(result_valid), 32'd0);
      cyc(0, 3'b000);
      chk("basic_e2_valid", 32'(result_valid), 32'd0);
      cyc(0, 3'b000);
      chk_result("basic", {8'd4, 8'd0, 8'd8}, 2'd0, 8'd8, 1'b0);
      cyc(0, 3'b000);
      chk("basic_e4_valid", 32'(result_valid), 32'd0);
      cyc(0, 3'b000);

      // Tie between n1 and n2 (5 each), then an empty window.
      for (int t = 0; t < 32; t++) begin
         cyc(1, (t < 5) ? 3'b110 : 3'b000);
         if (t == 18) chk_result("tie", {8'd5, 8'd5, 8'd0}, 2'd1, 8'd5, 1'b0);
         if (t == 19) chk("tie_acc_valid", 32'(result_valid), 32'd0);
      end
      cyc(0, 3'b000);
      cyc(0, 3'b000);
      cyc(0, 3'b000);
      chk_result("none", 24'd0, 2'd0, 8'd0, 1'b1);
      cyc(0, 3'b000);

      // Saturation: n0 spikes all 16 cycles; the 3-bit instance stops at 7.
      for (int c = 0; c < 16; c++)
         cyc(1, 3'b001);
      cyc(0, 3'b000);
      cyc(0, 3'b000);
      cyc(0, 3'b000);
      chk_result("sat_wide", {8'd0, 8'd0, 8'd16}, 2'd0, 8'd16, 1'b0);
      chk("sat_valid",  32'(sat_valid),  32'd1);
      chk("sat_counts", 32'(sat_counts), 32'({3'd0, 3'd0, 3'd7}));
      chk("sat_max",    32'(sat_max),    32'd7);
      chk("sat_winner", 32'(sat_winner), 32'd0);
      cyc(0, 3'b000);

      // Backpressure: A (n1=3) held, B dropped, C (n2=2) delivered.
      for (int t = 0; t < 52; t++) begin
         result_ready = (t >= 40);
         if (t < 3)                 cyc(1, 3'b010);
         else if (t >= 16 && t < 32) cyc(1, 3'b001);
         else if (t == 32 || t == 33) cyc(1, 3'b100);
         else                       cyc(t < 48, 3'b000);
         if (t == 17) chk("bp_e2_valid", 32'(result_valid), 32'd0);
         if (t == 18) chk_result("bp_a_first", {8'd0, 8'd3, 8'd0}, 2'd1, 8'd3, 1'b0);
         if (t == 30) chk("bp_no_overrun_yet", 32'(overrun), 32'd0);
         if (t == 31) chk("bp_overrun_set", 32'(overrun), 32'd1);
         if (t == 39) chk_result("bp_a_held", {8'd0, 8'd3, 8'd0}, 2'd1, 8'd3, 1'b0);
         if (t == 40) chk("bp_accept_valid", 32'(result_valid), 32'd0);
         if (t == 49) chk("bp_c_wait_valid", 32'(result_valid), 32'd0);
         if (t == 50) begin
            chk_result("bp_c", {8'd2, 8'd0, 8'd0}, 2'd2, 8'd2, 1'b0);
            chk("bp_overrun_sticky", 32'(overrun), 32'd1);
         end
      end
      clear_overrun = 1'b1;
      cyc(0, 3'b000);
      clear_overrun = 1'b0;
      chk("bp_overrun_clear", 32'(overrun), 32'd0);

      // Abort: en low at window index 9, n0 spiking whenever enabled.
      for (int t = 0; t < 30; t++) begin
         cyc(t != 9, 3'b001);
         if (t == 12) chk("abort_partial_valid", 32'(result_valid), 32'd0);
         if (t == 27) chk("abort_e2_valid", 32'(result_valid), 32'd0);
         if (t == 28) chk_result("abort", {8'd0, 8'd0, 8'd16}, 2'd0, 8'd16, 1'b0);
      end
      cyc(0, 3'b000);

      // Reset while holding a result, then a clean window.
      result_ready = 1'b0;
      for (int t = 0; t < 19; t++)
         cyc(t < 16, (t < 4) ? 3'b100 : 3'b000);
      chk_result("pre_rst", {8'd4, 8'd0, 8'd0}, 2'd2, 8'd4, 1'b0);
      rst = 1'b1;
      cyc(0, 3'b000);
      rst = 1'b0;
      result_ready = 1'b1;
      chk("hold_rst_valid",  32'(result_valid),  32'd0);
      chk("hold_rst_counts", 32'(result_counts), 32'd0);
      chk("hold_rst_max",    32'(result_max),    32'd0);
      for (int t = 0; t < 19; t++)
         cyc(t < 16, (t < 6) ? 3'b010 : 3'b000);
      chk_result("post_rst", {8'd0, 8'd6, 8'd0}, 2'd1, 8'd6, 1'b0);
      cyc(0, 3'b000);
      chk("post_rst_acc_valid", 32'(result_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
